// File: rtl/ones_comp_sub_arbiter.sv
// ones_comp_sub_arbiter
// Two-requester round-robin front end for one shared ones'-complement
// subtract datapath. Each accepted operand pair (A, B) runs A + ~B,
// then an end-around-carry add, and the tagged result is returned over
// a valid/ready response channel.
//
// Compile-time option:
//   ONES_COMP_NEG_ZERO_NORM_EN - when defined, an all-ones (-0) result is
//   rewritten to all-zeros (+0) in the end-around-carry stage. rsp_gt and
//   latency are unaffected.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate; accept one operand pair from the granted requester
// SUB   | add A to ~B, keep the low WIDTH bits and the carry-out
// EAC   | fold the carry back in, register result, id and gt flag
// RESP  | present the result until the consumer takes it

module ones_comp_sub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_id,
  output logic             rsp_gt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    EAC  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_served_q, last_served_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_gt_q, rsp_gt_d;

  logic             grant_vld;
  logic             grant_id;
  logic             accept;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] eac_sum;

  // Round-robin grant: a lone requester always wins, a tie goes to the
  // requester that was not served last.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_served_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = (state_q == IDLE) && grant_vld && !grant_id;
  assign req1_ready = (state_q == IDLE) && grant_vld &&  grant_id;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Datapath: stage-1 subtract as A + ~B with carry-out, stage-2 end-around carry.
  // A set carry means sum_q cannot be all ones, so the fold never overflows.
  always_comb begin
    sub_full = {1'b0, a_q} + {1'b0, ~b_q};
    eac_sum  = sum_q + {{(WIDTH-1){1'b0}}, cy_q};
`ifdef ONES_COMP_NEG_ZERO_NORM_EN
    if (&eac_sum) begin
      eac_sum = '0;
    end
`else
`endif
  end

  // Next-state and register-update logic for the sequencing FSM.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    sum_d         = sum_q;
    cy_d          = cy_q;
    rsp_result_d  = rsp_result_q;
    rsp_id_d      = rsp_id_q;
    rsp_gt_d      = rsp_gt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d           = grant_id ? req1_a : req0_a;
          b_d           = grant_id ? req1_b : req0_b;
          id_d          = grant_id;
          last_served_d = grant_id;
          state_d       = SUB;
        end
      end
      SUB: begin
        sum_d   = sub_full[WIDTH-1:0];
        cy_d    = sub_full[WIDTH];
        state_d = EAC;
      end
      EAC: begin
        rsp_result_d = eac_sum;
        rsp_gt_d     = cy_q;
        rsp_id_d     = id_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset favours requester 0 on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= 1'b0;
      sum_q         <= '0;
      cy_q          <= 1'b0;
      rsp_result_q  <= '0;
      rsp_id_q      <= 1'b0;
      rsp_gt_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      a_q           <= a_d;
      b_q           <= b_d;
      id_q          <= id_d;
      sum_q         <= sum_d;
      cy_q          <= cy_d;
      rsp_result_q  <= rsp_result_d;
      rsp_id_q      <= rsp_id_d;
      rsp_gt_q      <= rsp_gt_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_gt     = rsp_gt_q;

endmodule
